mc_cpu8: RTL and testbench
==========================

# mc_cpu8

Parametrised multi-cycle successor to the team's single-cycle 8-bit microprocessor. It executes the same 8-bit, 2-bit-opcode instruction format over a four-entry register file, with data and PC widths set by parameters. A state machine runs each instruction in its own sequence of cycles, and the instruction fetch and the data memory use valid/ready and req/ack handshakes instead of fixed single-cycle access. The block drives two 7-segment digits showing the last written-back value and reports sticky overflow and infinite-loop flags.

## Interface
- DATA_W, 8: register, ALU and data-memory word width (≥8).
- PC_W, 8: program counter width; wraps modulo 2^PC_W.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  in  8  fetched word: op[7:6], rs[5:4], rt[3:2], rd/imm[1:0].
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  core accepts an instruction this cycle.
- pc  out  PC_W  address of the instruction being fetched or executed.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DATA_W  data memory address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data; sampled on the dmem_ack cycle.
- dmem_ack  in  1  completes the outstanding request.
- lowerHex  out  7  active-low segments {g,f,e,d,c,b,a} for display[3:0].
- higherHex  out  7  same encoding for display[7:4].
- flags  out  2  [0] infinite loop (halted), [1] signed overflow; both sticky.

## Operation
- imm = sign-extend(instruction[1:0]) to DATA_W or PC_W. The range of imm is −2..+1.
- op 00 ADD: R[rd] = R[rs] + R[rt], modulo 2^DATA_W. If the add overflows as a signed operation, flags[1] is set.
- op 01 LOAD: R[rt] = mem[R[rs] + imm].
- op 10 STORE: mem[R[rs] + imm] = R[rt].
- op 11 BEQ: if R[rs] == R[rt], pc = pc + 1 + imm; otherwise pc = pc + 1.
- Address arithmetic for LOAD and STORE wraps and never sets flags[1].
- A taken BEQ with imm = −1 targets itself. In that case the core sets flags[0], enters HALT, and pc holds its value.
- All four registers are writable. No register is hardwired to zero.
- display register: loaded with the low 8 bits of every write-back. lowerHex and higherHex show it through a hex decoder for 0–F.
- States and transitions:
  - FETCH: instr_ready = 1. When instr_valid & instr_ready, the core latches IR and goes to EXEC.
  - EXEC: reads the registers and latches the ALU result or address.
    - BEQ: updates pc, goes to FETCH.
    - ADD: goes to WB.
    - LOAD or STORE: goes to MEM.
  - MEM: dmem_req = 1, with addr, we and wdata stable until dmem_ack.
    - On ack, STORE does pc+1 and goes to FETCH.
    - On ack, LOAD latches rdata and goes to WB.
  - WB: writes the register and display, does pc+1, goes to FETCH.
  - HALT: absorbing. All outputs except flags and hex are idle. Only reset leaves HALT.
- Reset (any time, including mid-MEM) sets the following; any outstanding memory request is abandoned:
  - state = FETCH and pc = 0;
  - all registers = 0, display = 0, flags = 0;
  - instr_ready = 1, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0;
  - lowerHex = higherHex = 7'b1000000 ("0").

## Timing
- Cycles per instruction, with zero-wait handshakes:
  - ADD: 3 (FETCH, EXEC, WB).
  - BEQ: 2.
  - STORE: 3.
  - LOAD: 4.
- Each cycle instr_valid is low in FETCH adds one cycle. Each cycle dmem_ack is late adds one cycle in MEM.
- dmem_ack is ignored outside MEM.
- A dmem_ack in the same cycle that dmem_req first rises is legal and completes MEM in one cycle.
- instruction is sampled only on the accept edge. The core never re-reads it.
- pc changes only on the EXEC (BEQ), MEM (STORE) or WB exit edge, so pc is stable throughout FETCH.
- A register write takes effect at the WB exit edge. The next instruction's EXEC sees the new value, so there are no hazards.
- flags and hex outputs are registered and update on the edge that writes their source.

## Structure
- Shared package holds:
  - state enum (FETCH, EXEC, MEM, WB, HALT);
  - opcode constants (OP_ADD, OP_LOAD, OP_STORE, OP_BEQ);
  - flag bit indices;
  - the 7-segment pattern constants.
- One sub-module: hex7seg (4-bit nibble to 7-bit active-low segments), instantiated twice.

## Test plan
- Reset then fetch ADD R1=R0+R0: after 3 cycles, instr_ready is high again, pc = 1, and both hex digits show "0".
- Preload regs using LOADs with dmem_rdata = 8'h7F and 8'h01, then ADD: R result = 8'h80, flags[1] = 1, higherHex = "8" (7'b0000000), lowerHex = "0".
- STORE with dmem_ack delayed 5 cycles: dmem_req, addr and wdata stay stable for 6 cycles, and pc increments only on the ack edge.
- BEQ equal with imm = +1 at pc = 4: pc = 6. BEQ with unequal operands: pc = 5.
- Taken BEQ with imm = −1 at pc = 9: flags[0] = 1, pc stays 9, instr_ready = 0 permanently, and instr_valid is ignored.
- Assert reset during MEM with dmem_req high: dmem_req drops immediately, and all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/mc_cpu8_pkg.sv
// Shared types and constants for the mc_cpu8 multi-cycle core.
package mc_cpu8_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned REG_N   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned FLAG_W  = 2;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    localparam int unsigned FLAG_HALT = 0;
    localparam int unsigned FLAG_OVF  = 1;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/mc_cpu8_hex7seg.sv
// Nibble to active-low 7-segment pattern decoder.
module hex7seg
    import mc_cpu8_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/mc_cpu8.sv
// Multi-cycle 8-bit-instruction core with handshaked fetch/data memory and hex display.
module mc_cpu8
    import mc_cpu8_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [PC_W-1:0]     pc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_ack,
    output logic [SEG_W-1:0]    lowerHex,
    output logic [SEG_W-1:0]    higherHex,
    output logic [FLAG_W-1:0]   flags
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                ready_q, ready_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEG_W-1:0]    lo_hex_q, hi_hex_q;
    logic [SEG_W-1:0]    lo_seg_c, hi_seg_c;
    logic [DATA_W-1:0]   regs_q [REG_N];
    logic                wb_en;

    logic [1:0]          op, rs, rt, rd;
    logic [DATA_W-1:0]   rs_val, rt_val, sum, imm_data;
    logic [PC_W-1:0]     imm_pc, pc_inc;
    logic                add_ovf;
    logic [1:0]          wb_addr;

    assign op       = ir_q[7:6];
    assign rs       = ir_q[5:4];
    assign rt       = ir_q[3:2];
    assign rd       = ir_q[1:0];
    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];
    assign imm_data = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    assign imm_pc   = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};
    assign pc_inc   = pc_q + PC_W'(1);
    assign sum      = rs_val + rt_val;
    assign add_ovf  = (rs_val[DATA_W-1] == rt_val[DATA_W-1]) &&
                      (sum[DATA_W-1] != rs_val[DATA_W-1]);
    assign wb_addr  = (op == OP_LOAD) ? rt : rd;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        flags_d  = flags_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wb_en    = 1'b0;

        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_ADD: begin
                        result_d = sum;
                        if (add_ovf) flags_d[FLAG_OVF] = 1'b1;
                        state_d = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        addr_d  = rs_val + imm_data;
                        wdata_d = rt_val;
                        we_d    = (op == OP_STORE);
                        state_d = MEM;
                    end
                    default: begin
                        // A taken branch to itself can never make progress
                        if (rs_val == rt_val && ir_q[1:0] == 2'b11) begin
                            flags_d[FLAG_HALT] = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d    = (rs_val == rt_val) ? pc_inc + imm_pc : pc_inc;
                            state_d = FETCH;
                        end
                    end
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    if (we_q) begin
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end else begin
                        result_d = dmem_rdata;
                        state_d  = WB;
                    end
                end
            end
            WB: begin
                wb_en   = 1'b1;
                pc_d    = pc_inc;
                state_d = FETCH;
            end
            default: state_d = HALT;
        endcase

        if (state_d == HALT) begin
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end
        ready_d = (state_d == FETCH);
        req_d   = (state_d == MEM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_hex_q <= SEG_0;
            hi_hex_q <= SEG_0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (wb_en) begin
                lo_hex_q <= lo_seg_c;
                hi_hex_q <= hi_seg_c;
            end
        end
    end

    // Register file: written only at WB exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[wb_addr] <= result_q;
        end
    end

    hex7seg u_hex_lo (.nibble(result_q[3:0]), .seg(lo_seg_c));
    hex7seg u_hex_hi (.nibble(result_q[7:4]), .seg(hi_seg_c));

    assign instr_ready = ready_q;
    assign pc          = pc_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign lowerHex    = lo_hex_q;
    assign higherHex   = hi_hex_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_mc_cpu8.sv
// Directed self-checking bench for mc_cpu8 with hand-computed expectations.
module tb_mc_cpu8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instruction;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic [6:0] lowerHex;
    logic [6:0] higherHex;
    logic [1:0] flags;

    int n_checks = 0;
    int n_errors = 0;

    mc_cpu8 #(.DATA_W(8), .PC_W(8)) dut (
        .clk(clk), .reset(reset),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .lowerHex(lowerHex), .higherHex(higherHex), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction after `stall` idle fetch cycles; answer memory after `delay` cycles.
    task automatic run(input string tag, input logic [7:0] ins, input int stall, input int delay,
                       input logic [7:0] rdata, output int cycles, output logic [7:0] addr_seen);
        int waited;
        logic [7:0] pc0;
        cycles    = 0;
        waited    = 0;
        addr_seen = 8'h00;
        pc0       = pc;
        check({tag, "_ready_pre"}, instr_ready, 1'b1);
        instr_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            cycles++;
        end
        if (stall > 0) check({tag, "_pc_stall"}, pc, pc0);
        instruction = ins;
        instr_valid = 1'b1;
        step();
        cycles++;
        instr_valid = 1'b0;
        instruction = 8'h00;
        while (!instr_ready && !flags[0] && cycles < 40) begin
            if (dmem_req) begin
                addr_seen  = dmem_addr;
                dmem_rdata = rdata;
                dmem_ack   = (waited == delay);
                waited++;
            end else begin
                dmem_ack = 1'b0;
            end
            step();
            cycles++;
        end
        dmem_ack = 1'b0;
        check({tag, "_done"}, instr_ready | flags[0], 1'b1);
    endtask

    int         cyc;
    logic [7:0] a;

    initial begin
        reset       = 1'b1;
        instruction = 8'h00;
        instr_valid = 1'b0;
        dmem_rdata  = 8'h00;
        dmem_ack    = 1'b0;
        #12;
        check("rst_ready", instr_ready, 1'b1);
        check("rst_req",   dmem_req,    1'b0);
        check("rst_pc",    pc,          8'd0);
        check("rst_flags", flags,       2'b00);
        check("rst_lo",    lowerHex,    7'b1000000);
        check("rst_hi",    higherHex,   7'b1000000);
        check("rst_addr",  dmem_addr,   8'h00);
        reset = 1'b0;

        // pc0: ADD R1 = R0 + R0
        run("add0", 8'h01, 0, 0, 8'h00, cyc, a);
        check("add0_cyc", cyc, 3);
        check("add0_pc",  pc, 8'd1);
        check("add0_lo",  lowerHex, 7'b1000000);
        check("add0_hi",  higherHex, 7'b1000000);

        // pc1: LOAD R1 = mem[R0+0] = 7F
        run("ld1", 8'h44, 0, 0, 8'h7F, cyc, a);
        check("ld1_cyc",  cyc, 4);
        check("ld1_pc",   pc, 8'd2);
        check("ld1_addr", a, 8'h00);
        check("ld1_lo",   lowerHex, 7'b0001110);
        check("ld1_hi",   higherHex, 7'b1111000);

        // pc2: LOAD R2 = mem[R0+1] = 01
        run("ld2", 8'h49, 0, 0, 8'h01, cyc, a);
        check("ld2_cyc",  cyc, 4);
        check("ld2_addr", a, 8'h01);
        check("ld2_lo",   lowerHex, 7'b1111001);
        check("ld2_hi",   higherHex, 7'b1000000);

        // pc3: ADD R3 = R1 + R2 = 80, signed overflow
        run("add3", 8'h1B, 0, 0, 8'h00, cyc, a);
        check("add3_cyc",   cyc, 3);
        check("add3_pc",    pc, 8'd4);
        check("add3_flags", flags, 2'b10);
        check("add3_hi",    higherHex, 7'b0000000);
        check("add3_lo",    lowerHex, 7'b1000000);

        // pc4: BEQ R1,R2 unequal -> 5; pc5: BEQ R0,R0 imm -2 -> 4; pc4: BEQ R0,R0 imm +1 -> 6
        run("bne", 8'hD9, 0, 0, 8'h00, cyc, a);
        check("bne_cyc", cyc, 2);
        check("bne_pc",  pc, 8'd5);
        run("bback", 8'hC2, 0, 0, 8'h00, cyc, a);
        check("bback_pc", pc, 8'd4);
        run("beq", 8'hC1, 0, 0, 8'h00, cyc, a);
        check("beq_cyc", cyc, 2);
        check("beq_pc",  pc, 8'd6);

        // pc6: STORE mem[R3-2] = R1 with ack five cycles late
        instruction = 8'hB6;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            check("st_req",   dmem_req,   1'b1);
            check("st_we",    dmem_we,    1'b1);
            check("st_addr",  dmem_addr,  8'h7E);
            check("st_wdata", dmem_wdata, 8'h7F);
            check("st_pc",    pc,         8'd6);
            dmem_ack = (k == 5);
            step();
        end
        dmem_ack = 1'b0;
        check("st_req_off", dmem_req, 1'b0);
        check("st_pc_ack",  pc, 8'd7);
        check("st_ready",   instr_ready, 1'b1);

        // pc7: STORE mem[R2+1] = R3, zero-wait
        run("st2", 8'hAD, 0, 0, 8'h00, cyc, a);
        check("st2_cyc",  cyc, 3);
        check("st2_addr", a, 8'h02);
        check("st2_pc",   pc, 8'd8);

        // pc8: ADD R0 = R1 + R2 after two idle fetch cycles
        run("add8", 8'h18, 2, 0, 8'h00, cyc, a);
        check("add8_cyc", cyc, 5);
        check("add8_pc",  pc, 8'd9);

        // pc9: BEQ R1,R1 imm -1 -> halt
        run("halt", 8'hD7, 0, 0, 8'h00, cyc, a);
        check("halt_cyc",   cyc, 2);
        check("halt_flags", flags, 2'b11);
        check("halt_pc",    pc, 8'd9);
        instruction = 8'h01;
        instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("halt_hold_pc",    pc, 8'd9);
            check("halt_hold_ready", instr_ready, 1'b0);
            check("halt_hold_req",   dmem_req, 1'b0);
        end
        instr_valid = 1'b0;
        check("halt_hi", higherHex, 7'b0000000);

        // Asynchronous reset out of HALT
        #2 reset = 1'b1;
        #1;
        check("ar_flags", flags, 2'b00);
        check("ar_pc",    pc, 8'd0);
        check("ar_ready", instr_ready, 1'b1);
        step();
        reset = 1'b0;

        // Registers cleared: R1 == R2 now, so BEQ imm +1 at pc0 -> 2
        run("bclr", 8'hD9, 0, 0, 8'h00, cyc, a);
        check("bclr_pc", pc, 8'd2);

        // Reset while a LOAD request to R0-1 is outstanding
        instruction = 8'h47;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("mr_req",  dmem_req, 1'b1);
        check("mr_addr", dmem_addr, 8'hFF);
        #2 reset = 1'b1;
        #1;
        check("mr_req_off", dmem_req, 1'b0);
        check("mr_addr0",   dmem_addr, 8'h00);
        check("mr_ready",   instr_ready, 1'b1);
        check("mr_pc",      pc, 8'd0);
        check("mr_lo",      lowerHex, 7'b1000000);
        step();
        reset = 1'b0;

        run("post", 8'h01, 0, 0, 8'h00, cyc, a);
        check("post_cyc", cyc, 3);
        check("post_pc",  pc, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
